// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 frame receiver: parity modes, FSM states, parity check.
package ps2_rx_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Returns 1 when the received parity bit disagrees with the selected mode.
    function automatic logic parity_err(input logic [1:0] mode,
                                        input logic       data_xor,
                                        input logic       par_bit);
        logic err;
        err = 1'b0;
        case (mode)
            PARITY_ODD:  err = ((data_xor ^ par_bit) != 1'b1);
            PARITY_EVEN: err = ((data_xor ^ par_bit) != 1'b0);
            default:     err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_line_sync.sv
// Synchronises the PS/2 clock and data pins and flags falling edges of the clock.
module ps2_frame_receiver_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_clk_i,
    input  logic serial_data_i,
    output logic sample_evt_o,
    output logic sample_bit_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   evt_q, evt_d;
    logic                   bit_q, bit_d;

    // Shift the pins through the synchroniser chain and detect a 1->0 on the last clock stage.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], serial_clk_i};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], serial_data_i};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        evt_d       = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        bit_d       = data_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser flops reset high so an idle line never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            evt_q       <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            evt_q       <= evt_d;
            bit_q       <= bit_d;
        end
    end

    assign sample_evt_o = evt_q;
    assign sample_bit_o = bit_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: deframes start/data/parity/stop, checks errors, delivers via valid/ready.
module ps2_frame_receiver
    import ps2_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_clk,
    input  logic              serial_data,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    logic sample_evt, sample_bit;

    ps2_frame_receiver_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk          (clk),
        .reset        (reset),
        .serial_clk_i (serial_clk),
        .serial_data_i(serial_data),
        .sample_evt_o (sample_evt),
        .sample_bit_o (sample_bit)
    );

    ps2_state_e        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              deliver_q, deliver_d;
    logic              busy_q;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_out_q, ferr_out_d;
    logic              ovr_q, ovr_d;

    // Deframing FSM, shift register and stall timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        deliver_d = 1'b0;
        tmo_d     = (state_q == StIdle || sample_evt) ? '0 : tmo_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (sample_evt && !sample_bit) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            StData: begin
                if (sample_evt) begin
                    shift_d   = {sample_bit, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (sample_evt) begin
                    perr_d  = parity_err(2'(PARITY_MODE), ^shift_q, sample_bit);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (sample_evt) begin
                    ferr_d    = ~sample_bit;
                    state_d   = StIdle;
                    deliver_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled frame is silently abandoned.
        if (state_q != StIdle && !sample_evt && tmo_q == TmoLast) begin
            state_d = StIdle;
        end
    end

    // Output holding register: load when empty or being accepted, otherwise drop and flag overrun.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;

        if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || frame_ready) begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_q      <= '0;
            deliver_q  <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            tmo_q      <= tmo_d;
            deliver_q  <= deliver_d;
            busy_q     <= (state_d != StIdle);
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign frame_data    = data_q;
    assign frame_valid   = valid_q;
    assign parity_error  = perr_out_q;
    assign framing_error = ferr_out_q;
    assign overrun       = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: default build plus a 7-bit no-parity build.
module tb_ps2_frame_receiver;

    localparam int unsigned TMO = 5000;

    logic       clk;
    logic       reset;
    logic       sclk, sdat, frame_ready;
    logic [7:0] frame_data;
    logic       frame_valid, parity_error, framing_error, overrun, busy;
    logic       sclk7, sdat7, ready7;
    logic [6:0] frame_data7;
    logic       valid7, perr7, ferr7, ovr7, busy7;

    int n_cmp  = 0;
    int n_fail = 0;
    int ovr_cnt = 0;

    ps2_frame_receiver #(
        .DATA_W(8), .PARITY_MODE(1), .TIMEOUT_CYC(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .serial_clk(sclk), .serial_data(sdat),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun),
        .busy(busy)
    );

    ps2_frame_receiver #(
        .DATA_W(7), .PARITY_MODE(0), .TIMEOUT_CYC(TMO), .SYNC_STAGES(2)
    ) dut7 (
        .clk(clk), .reset(reset), .serial_clk(sclk7), .serial_data(sdat7),
        .frame_data(frame_data7), .frame_valid(valid7), .frame_ready(ready7),
        .parity_error(perr7), .framing_error(ferr7), .overrun(ovr7),
        .busy(busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts overrun pulse cycles of the default DUT.
    always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at 3ms, required finish");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b, input bit sel);
        @(negedge clk);
        if (sel) sdat7 = b; else sdat = b;
        repeat (10) @(negedge clk);
        if (sel) sclk7 = 1'b0; else sclk = 1'b0;
        repeat (20) @(negedge clk);
        if (sel) sclk7 = 1'b1; else sclk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_body(input logic [8:0] d, input int nbits, input bit has_par,
                             input logic par, input bit sel);
        ps2_bit(1'b0, sel);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], sel);
        if (has_par) ps2_bit(par, sel);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit has_par,
                              input logic par, input logic stop, input bit sel);
        send_body(d, nbits, has_par, par, sel);
        ps2_bit(stop, sel);
        @(negedge clk);
        if (sel) sdat7 = 1'b1; else sdat = 1'b1;
    endtask

    task automatic accept_default(input string name);
        @(negedge clk) frame_ready = 1'b1;
        @(negedge clk) frame_ready = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            $display("FAIL %s_accept: frame_valid=%b required 0", name, frame_valid); n_fail++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({frame_valid, parity_error, framing_error, overrun, busy} !== 5'b0 ||
            frame_data !== 8'h00) begin
            $display("FAIL reset_outputs: v/pe/fe/ovr/busy=%b data=%h required 0/00",
                     {frame_valid, parity_error, framing_error, overrun, busy}, frame_data);
            n_fail++;
        end
        n_cmp++;
        if ({valid7, perr7, ferr7, ovr7, busy7} !== 5'b0 || frame_data7 !== 7'h00) begin
            $display("FAIL reset_outputs7: flags=%b data=%h required 0/00",
                     {valid7, perr7, ferr7, ovr7, busy7}, frame_data7);
            n_fail++;
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        send_frame(9'h01C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C) begin
            $display("FAIL basic_data: valid=%b data=%h required 1/1c", frame_valid, frame_data);
            n_fail++;
        end
        n_cmp++;
        if (parity_error !== 1'b0 || framing_error !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_flags: pe=%b fe=%b busy=%b required 0/0/0",
                     parity_error, framing_error, busy);
            n_fail++;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C) begin
            $display("FAIL basic_hold: valid=%b data=%h required 1/1c", frame_valid, frame_data);
            n_fail++;
        end
        accept_default("basic");
    endtask

    task automatic test_parity;
        send_frame(9'h01C, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C || parity_error !== 1'b1 ||
            framing_error !== 1'b0) begin
            $display("FAIL parity_bad: v=%b data=%h pe=%b fe=%b required 1/1c/1/0",
                     frame_valid, frame_data, parity_error, framing_error);
            n_fail++;
        end
        accept_default("parity_bad");
        send_frame(9'h0F0, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'hF0 || parity_error !== 1'b0) begin
            $display("FAIL parity_good: v=%b data=%h pe=%b required 1/f0/0",
                     frame_valid, frame_data, parity_error);
            n_fail++;
        end
        accept_default("parity_good");
    endtask

    task automatic test_framing;
        send_frame(9'h01C, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C || framing_error !== 1'b1 ||
            parity_error !== 1'b0) begin
            $display("FAIL framing: v=%b data=%h fe=%b pe=%b required 1/1c/1/0",
                     frame_valid, frame_data, framing_error, parity_error);
            n_fail++;
        end
        accept_default("framing");
    endtask

    task automatic test_timeout;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            $display("FAIL timeout_busy_before: busy=%b required 1", busy); n_fail++;
        end
        repeat (TMO + 50) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || frame_valid !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL timeout_abort: busy=%b valid=%b ovr=%b required 0/0/0",
                     busy, frame_valid, overrun);
            n_fail++;
        end
        @(negedge clk) sdat = 1'b1;
        send_frame(9'h0F0, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'hF0 || parity_error !== 1'b0 ||
            framing_error !== 1'b0) begin
            $display("FAIL timeout_recover: v=%b data=%h pe=%b fe=%b required 1/f0/0/0",
                     frame_valid, frame_data, parity_error, framing_error);
            n_fail++;
        end
        accept_default("timeout_recover");
    endtask

    task automatic test_back_to_back;
        int  ovr0;
        bit  found;
        frame_ready = 1'b0;
        send_frame(9'h01C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        ovr0 = ovr_cnt;
        send_frame(9'h032, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C) begin
            $display("FAIL overrun_hold: v=%b data=%h required 1/1c", frame_valid, frame_data);
            n_fail++;
        end
        n_cmp++;
        if (ovr_cnt - ovr0 != 1) begin
            $display("FAIL overrun_pulse: pulses=%0d required 1", ovr_cnt - ovr0); n_fail++;
        end

        // Second 0x32 with frame_ready raised exactly in its delivery cycle.
        ovr0 = ovr_cnt;
        send_body(9'h032, 8, 1'b1, 1'b0, 1'b0);
        @(negedge clk) sdat = 1'b1;
        repeat (10) @(negedge clk);
        sclk = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            $display("FAIL simul_wait: busy never fell, required fall within 50 cycles");
            n_fail++;
        end
        frame_ready = 1'b1;
        @(negedge clk) frame_ready = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h32) begin
            $display("FAIL simul_load: v=%b data=%h required 1/32", frame_valid, frame_data);
            n_fail++;
        end
        repeat (15) @(negedge clk);
        sclk = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ovr_cnt != ovr0 || frame_data !== 8'h32) begin
            $display("FAIL simul_no_overrun: pulses=%0d data=%h required 0/32",
                     ovr_cnt - ovr0, frame_data);
            n_fail++;
        end
        accept_default("simul");
    endtask

    task automatic test_reset_mid;
        send_frame(9'h01C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({frame_valid, parity_error, framing_error, overrun, busy} !== 5'b0 ||
            frame_data !== 8'h00) begin
            $display("FAIL reset_mid: v/pe/fe/ovr/busy=%b data=%h required 0/00",
                     {frame_valid, parity_error, framing_error, overrun, busy}, frame_data);
            n_fail++;
        end
        reset = 1'b0;
        sdat  = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(9'h01C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== 8'h1C || parity_error !== 1'b0 ||
            framing_error !== 1'b0) begin
            $display("FAIL reset_recover: v=%b data=%h pe=%b fe=%b required 1/1c/0/0",
                     frame_valid, frame_data, parity_error, framing_error);
            n_fail++;
        end
        accept_default("reset_recover");
    endtask

    task automatic test_mode7;
        send_frame(9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (valid7 !== 1'b1 || frame_data7 !== 7'h55 || perr7 !== 1'b0 || ferr7 !== 1'b0) begin
            $display("FAIL mode7: v=%b data=%h pe=%b fe=%b required 1/55/0/0",
                     valid7, frame_data7, perr7, ferr7);
            n_fail++;
        end
        @(negedge clk) ready7 = 1'b1;
        @(negedge clk) ready7 = 1'b0;
        n_cmp++;
        if (valid7 !== 1'b0) begin
            $display("FAIL mode7_accept: valid=%b required 0", valid7); n_fail++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        sclk        = 1'b1;
        sdat        = 1'b1;
        frame_ready = 1'b0;
        sclk7       = 1'b1;
        sdat7       = 1'b1;
        ready7      = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_mode7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
